// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared types and default widths for the sprite frame RAM arbiter.
// Optional build macro used by this slice: SPRITE_ARB_FIXED_PRIO_EN (see sprite_rom_arbiter).
package sprite_arb_pkg;

  // Arbiter FSM: wait for a request, or stream one burst of addresses.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Default widths matching the 2500-entry, 5-bit palette-index frame RAM.
  localparam int ADDR_W = 19;
  localparam int DATA_W = 5;
  localparam int LEN_W  = 6;

  // One sprite row, the typical burst a draw engine asks for.
  localparam int SPRITE_ROW_LEN = 50;

endpackage

// File: rtl/sprite_rr_picker.sv
// sprite_rr_picker: combinational rotating-priority picker.
// Scans req starting at ptr and wrapping modulo N; the first set bit wins.
// With ptr tied to zero it degenerates to fixed lowest-index priority.
module sprite_rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);
  import sprite_arb_pkg::*;

  // Rotating scan from ptr; only the first hit is recorded.
  always_comb begin
    int p;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = IDW'(p);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one frame RAM read port between NUM_REQ sprite clients.
// Grants whole bursts, streams consecutive addresses, and tags returned pixels.
// Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no rotating pointer); default build is round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = sprite_arb_pkg::ADDR_W,
  parameter int DATA_W  = sprite_arb_pkg::DATA_W,
  parameter int LEN_W   = sprite_arb_pkg::LEN_W,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_read_address,
  input  logic [DATA_W-1:0]         rom_data_Out,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [IDW-1:0]            rd_id,
  output logic                      rd_last
);
  import sprite_arb_pkg::*;

  state_t             state;
  logic [IDW-1:0]     owner;
  logic [ADDR_W-1:0]  base;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   beat;

  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     win;
  logic               any;

  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   eff_len;
  logic               issue;
  logic               last;

  sprite_rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;
  assign ptr = rr_ptr;

  // Rotate priority to the client just after the one granted.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
    end else if (state == IDLE && any) begin
      rr_ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
    end
  end
`endif

  // Winner's request fields; a zero length still fetches one beat.
  assign sel_addr = req_addr[win*ADDR_W +: ADDR_W];
  assign sel_len  = req_len[win*LEN_W +: LEN_W];
  assign eff_len  = (sel_len == '0) ? LEN_W'(1) : sel_len;

  // Every BURST cycle presents a valid address; the final beat ends the burst.
  assign issue   = (state == BURST);
  assign last    = issue && (beat == len - LEN_W'(1));
  assign busy    = issue;
  assign rd_data = rom_data_Out;

  // Arbitration and address sequencing; the return to IDLE after the final
  // beat is the bubble that lets the owner drop req before re-arbitration.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state            <= IDLE;
      ack              <= '0;
      rom_read_address <= '0;
      owner            <= '0;
      base             <= '0;
      len              <= '0;
      beat             <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            owner            <= win;
            base             <= sel_addr;
            len              <= eff_len;
            beat             <= '0;
            rom_read_address <= sel_addr;
            ack              <= grant;
            state            <= BURST;
          end
        end
        BURST: begin
          if (last) begin
            state <= IDLE;
          end else begin
            beat             <= beat + LEN_W'(1);
            rom_read_address <= base + ADDR_W'(beat) + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay the beat tags one edge to line up with the RAM's registered data.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_id    <= owner;
      rd_last  <= last;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed self-checking bench for sprite_rom_arbiter.
// Honours SPRITE_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 5;
  localparam int LW = 6;
  localparam int IW = 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    ack;
  logic            busy;
  logic [AW-1:0]   rom_read_address;
  logic [DW-1:0]   rom_data = '0;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [IW-1:0]   rd_id;
  logic            rd_last;

  int tests = 0;
  int fails = 0;

  sprite_rom_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW), .IDW (IW)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .req              (req),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .ack              (ack),
    .busy             (busy),
    .rom_read_address (rom_read_address),
    .rom_data_Out     (rom_data),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .rd_id            (rd_id),
    .rd_last          (rd_last)
  );

  always #5 Clk = ~Clk;

  // Frame RAM stand-in: content is a fixed function of address, registered read.
  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return a[4:0] ^ a[9:5] ^ a[18:14];
  endfunction

  always @(posedge Clk) rom_data <= romf(rom_read_address);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Packed {rd_valid, rd_id, rd_last}.
  task automatic check_rd(input string tag, input logic v, input logic [IW-1:0] id, input logic l);
    check(tag, 32'({rd_valid, rd_id, rd_last}), 32'({v, id, l}));
  endtask

  initial begin
    int exp_id;

    // Reset state
    tick(); tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(rom_read_address), 32'd0);
    check_rd("rst_rd", 1'b0, 2'd0, 1'b0);
    Reset_n = 1'b1;
    tick();

    // Single client 0, addr 100, len 3
    set_client(0, 19'd100, 6'd3);
    req = 4'b0001;
    tick();                                   // C1
    check("t1_ack", 32'(ack), 32'b0001);
    check("t1_addr_c1", 32'(rom_read_address), 32'd100);
    check("t1_busy", 32'(busy), 32'd1);
    check_rd("t1_rd_c1", 1'b0, 2'd0, 1'b0);
    req = '0;
    tick();                                   // C2
    check("t1_ack_c2", 32'(ack), 32'd0);
    check("t1_addr_c2", 32'(rom_read_address), 32'd101);
    check_rd("t1_rd_c2", 1'b1, 2'd0, 1'b0);
    check("t1_data_c2", 32'(rd_data), 32'(romf(19'd100)));
    tick();                                   // C3
    check("t1_addr_c3", 32'(rom_read_address), 32'd102);
    check_rd("t1_rd_c3", 1'b1, 2'd0, 1'b0);
    check("t1_data_c3", 32'(rd_data), 32'(romf(19'd101)));
    tick();                                   // C4
    check("t1_busy_c4", 32'(busy), 32'd0);
    check_rd("t1_rd_c4", 1'b1, 2'd0, 1'b1);
    check("t1_data_c4", 32'(rd_data), 32'(romf(19'd102)));
    tick();                                   // C5
    check_rd("t1_rd_c5", 1'b0, 2'd0, 1'b0);

    // Client 2, len 0 at addr 2499: exactly one beat
    set_client(2, 19'd2499, 6'd0);
    req = 4'b0100;
    tick();
    check("t2_ack", 32'(ack), 32'b0100);
    check("t2_addr", 32'(rom_read_address), 32'd2499);
    req = '0;
    tick();
    check("t2_busy", 32'(busy), 32'd0);
    check_rd("t2_rd", 1'b1, 2'd2, 1'b1);
    check("t2_data", 32'(rd_data), 32'(romf(19'd2499)));
    tick();
    check_rd("t2_rd_after", 1'b0, 2'd2, 1'b0);

    // Reset mid-idle so the pointer starts at 0 for the fairness run
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;

    // All four clients held, len 1: one grant every 2 cycles
    for (int i = 0; i < N; i++) set_client(i, 19'(i * 1000), 6'd1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = g % N;
`endif
      tick();
      check($sformatf("t3_ack_g%0d", g), 32'(ack), 32'(1 << exp_id));
      check($sformatf("t3_addr_g%0d", g), 32'(rom_read_address), 32'(exp_id * 1000));
      if (g == 4) req = '0;
      tick();
      check($sformatf("t3_bubble_g%0d", g), 32'({busy, ack}), 32'd0);
      check_rd($sformatf("t3_rd_g%0d", g), 1'b1, IW'(exp_id), 1'b1);
      check($sformatf("t3_data_g%0d", g), 32'(rd_data), 32'(romf(19'(exp_id * 1000))));
    end
    tick();
    check_rd("t3_rd_end", 1'b0, 2'd0, 1'b0);

    // Client 1 len 50; client 3 raises req mid-burst
    set_client(1, 19'd5000, 6'd50);
    set_client(3, 19'd7000, 6'd2);
    req = 4'b0010;
    tick();                                   // C1
    check("t4_ack1", 32'(ack), 32'b0010);
    req = '0;
    for (int c = 2; c <= 51; c++) begin
      tick();
      if (c == 10) req[3] = 1'b1;
      check($sformatf("t4_ack_c%0d", c), 32'(ack), 32'd0);
      check_rd($sformatf("t4_rd_c%0d", c), 1'b1, 2'd1, (c == 51));
      if (c <= 50) check($sformatf("t4_addr_c%0d", c), 32'(rom_read_address), 32'(5000 + c - 1));
    end
    tick();                                   // C52
    check("t4_ack3", 32'(ack), 32'b1000);
    check("t4_addr3", 32'(rom_read_address), 32'd7000);
    check_rd("t4_rd_c52", 1'b0, 2'd1, 1'b0);
    req = '0;
    tick();
    check_rd("t4_rd3_first", 1'b1, 2'd3, 1'b0);
    tick();
    check_rd("t4_rd3_last", 1'b1, 2'd3, 1'b1);
    tick();

    // Address wrap at 2^19-1
    set_client(0, 19'd524287, 6'd2);
    req = 4'b0001;
    tick();
    check("t5_ack", 32'(ack), 32'b0001);
    check("t5_addr0", 32'(rom_read_address), 32'd524287);
    req = '0;
    tick();
    check("t5_addr1", 32'(rom_read_address), 32'd0);
    check("t5_data0", 32'(rd_data), 32'(romf(19'd524287)));
    tick();
    check_rd("t5_rd_last", 1'b1, 2'd0, 1'b1);
    check("t5_data1", 32'(rd_data), 32'(romf(19'd0)));
    tick();

    // Reset during beat 10 of a 50-beat burst
    set_client(2, 19'd300, 6'd50);
    req = 4'b0100;
    tick();                                   // C1
    check("t6_ack", 32'(ack), 32'b0100);
    req = '0;
    for (int c = 2; c <= 11; c++) tick();     // C11: beat 10
    check("t6_addr_beat10", 32'(rom_read_address), 32'd310);
    Reset_n = 1'b0;
    tick();                                   // C12
    check("t6_rst_ack_busy", 32'({ack, busy}), 32'd0);
    check("t6_rst_addr", 32'(rom_read_address), 32'd0);
    check_rd("t6_rst_rd", 1'b0, 2'd0, 1'b0);
    tick();                                   // C13
    check_rd("t6_rst_rd2", 1'b0, 2'd0, 1'b0);
    set_client(1, 19'd11, 6'd1);
    set_client(3, 19'd33, 6'd1);
    req = 4'b1010;
    Reset_n = 1'b1;
    tick();                                   // C14
    check("t6_post_ack", 32'(ack), 32'b0010);
    check("t6_post_addr", 32'(rom_read_address), 32'd11);
    check_rd("t6_post_rd", 1'b0, 2'd0, 1'b0);
    req = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares the single read port of a sprite frame RAM (2500 x palette-index image, 1-cycle registered read) between NUM_REQ drawing clients, e.g. player tanks, enemy tanks and bullets.
- Each client requests a burst of consecutive addresses, typically one 50-pixel sprite row.
- The arbiter grants bursts round-robin and drives the frame RAM read address.
- It returns tagged pixel data with valid/last flags.
- Sits between the sprite-draw engines and the frameRAM instances, feeding the colour mapper.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
ADDR_W, 19, frame RAM address width
DATA_W, 5, frame RAM data width
LEN_W, 6, burst length field width (max burst 63)
IDW, $clog2(NUM_REQ), requester id width (derived)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-client burst request, held until ack
req_addr  in  NUM_REQ*ADDR_W  per-client start address, client i at bits [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  per-client beat count; 0 is treated as 1
ack  out  NUM_REQ  one-hot, single-cycle burst-accepted pulse
busy  out  1  high while in BURST
rom_read_address  out  ADDR_W  registered address to frameRAM read_address
rom_data_Out  in  DATA_W  frameRAM data_Out
rd_valid  out  1  rd_data valid this cycle
rd_data  out  DATA_W  pass-through of rom_data_Out
rd_id  out  IDW  owner of the returned beat
rd_last  out  1  final beat of the burst

Behaviour:
- Reset (Reset_n low at an edge):
  - state IDLE, rr_ptr 0.
  - ack, busy, rd_valid, rd_last, rd_id, rom_read_address all 0.
  - In-flight beats are discarded; no rd_valid follows a reset.
- FSM has two states, IDLE and BURST.
- IDLE, no req: stay in IDLE.
- IDLE, any req at edge E0:
  - Winner is the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Latch owner, base = req_addr[owner], len = max(req_len[owner], 1); beat counter = 0.
  - rom_read_address <= base; go to BURST; rr_ptr <= owner+1 mod NUM_REQ.
- BURST:
  - First BURST cycle: ack[owner] = 1 and issue flag = 1.
  - Each later edge while beat < len-1: beat++, rom_read_address <= base+beat+1.
  - Issue flag stays high every BURST cycle.
  - When beat == len-1, the next edge returns to IDLE. This gives one mandatory bubble cycle per burst, so the owner sees ack before re-arbitration and a held req is never double-accepted.
- Address arithmetic: modulo 2^ADDR_W, no range clamping.
- Requests are not evaluated in BURST. Clients must hold req, addr and len stable until ack.
- Return path:
  - rd_valid, rd_id and rd_last are the issue flag, owner and last-beat flag delayed by one register.
  - This aligns them with rom_data_Out, which the frameRAM registers one edge after the address.
- Latency: request sampled at E0 -> address in cycle C1 -> data with rd_valid in C2. Beat j has its data in C(2+j).
- Throughput: len beats per len+1 cycles.
- A req deasserted before ack is legal: the request is withdrawn.
- A req rising during BURST is evaluated at the first IDLE edge.

Optional Feature:
Macro SPRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not instantiated.
- Undefined: round-robin as above.

Decomposition:
- sprite_arb_pkg holds:
  - the state enum typedef (IDLE, BURST);
  - default width constants ADDR_W=19, DATA_W=5, LEN_W=6;
  - SPRITE_ROW_LEN=50.
- One sub-module: sprite_rr_picker.
  - Combinational.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Reused for the fixed-priority build with ptr tied to 0.

Test Plan:
- Single client: req[0], addr 100, len 3 -> ack[0] in C1. rom_read_address 100,101,102 in C1-C3. rd_valid with rd_id 0 in C2-C4; rd_last in C4 only. IDLE in C4.
- len 0 on client 2, addr 2499 -> exactly one beat, rd_last=1, rd_data = mem[2499].
- All four clients holding req, len 1 -> grant order 0,1,2,3,0, one grant every 2 cycles. Under SPRITE_ARB_FIXED_PRIO_EN, client 0 wins every time.
- Client 1 starts a burst with len 50. Client 3 raises req mid-burst -> client 3 is acked only after client 1's 50th beat plus one bubble; no interleaving of rd_id.
- Address wrap: addr 2^19-1, len 2 -> addresses 524287 then 0.
- Reset_n low during beat 10 of a 50-beat burst -> all outputs 0 next cycle, no further rd_valid. After release, a pending req is arbitrated from rr_ptr 0.
